// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state type and
// framing/baud constants.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

  localparam int unsigned CLKS_PER_BIT_115200 = 868;
  localparam int unsigned DATA_BITS           = 8;
  localparam int unsigned FRAME_BITS          = 10;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count,
// so every bit is exactly CLKS_PER_BIT cycles long.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = (clear || tick) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and sends each as a UART 8N1 frame,
// LSB first. All outputs are registered.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         fifo_empty,
  input  logic [N-1:0] fifo_dout,
  output logic         fifo_pop,
  output logic         tx,
  output logic         busy,
  output logic         tx_done
);

  localparam int unsigned BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  if (N != DATA_BITS) begin : g_n_chk
    $error("fifo_uart_tx: N must be 8 for 8N1 framing");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic           tx_q, tx_d;
  logic           pop_q, pop_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           baud_clr;
  logic           tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clr),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_clr = 1'b0;
    case (state_q)
      ST_IDLE:  if (en && !fifo_empty) state_d = ST_POP;
      ST_POP:   state_d = ST_LATCH;
      ST_LATCH: begin
        shift_d  = fifo_dout;
        baud_clr = 1'b1;
        state_d  = ST_START;
      end
      ST_START: if (tick) begin
        bit_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA:  if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + BW'(1);
        if (bit_q == LAST_BIT) state_d = ST_STOP;
      end
      ST_STOP:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they line up
    // cycle-for-cycle with state_q while staying glitch-free.
    tx_d = 1'b1;
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shift_d[0];
    pop_d  = (state_d == ST_POP);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx       = tx_q;
  assign fifo_pop = pop_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance at 4 clks/bit for framing and
// flow behaviour, one at 868 clks/bit for bit-period timing.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: CLKS_PER_BIT=4, instance B: CLKS_PER_BIT=868
  logic       a_rst, a_en, a_pop, a_tx, a_busy, a_done;
  logic       b_rst, b_en, b_pop, b_tx, b_busy, b_done;
  logic       a_empty = 1'b1, b_empty = 1'b1;
  logic [7:0] a_dout = 8'h00, b_dout = 8'h00;
  logic       a_wr = 1'b0, b_wr = 1'b0;
  logic [7:0] a_wd = 8'h00, b_wd = 8'h00;
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];

  fifo_uart_tx #(.N(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(a_rst), .en(a_en), .fifo_empty(a_empty), .fifo_dout(a_dout),
    .fifo_pop(a_pop), .tx(a_tx), .busy(a_busy), .tx_done(a_done)
  );

  fifo_uart_tx #(.N(8), .CLKS_PER_BIT(868)) dut868 (
    .clk(clk), .rst(b_rst), .en(b_en), .fifo_empty(b_empty), .fifo_dout(b_dout),
    .fifo_pop(b_pop), .tx(b_tx), .busy(b_busy), .tx_done(b_done)
  );

  // FIFO models with one-cycle registered read data
  always @(posedge clk) begin
    if (a_pop && a_q.size() > 0) a_dout <= a_q.pop_front();
    if (a_wr) a_q.push_back(a_wd);
    a_empty <= (a_q.size() == 0);
    if (b_pop && b_q.size() > 0) b_dout <= b_q.pop_front();
    if (b_wr) b_q.push_back(b_wd);
    b_empty <= (b_q.size() == 0);
  end

  // Monitor for instance A: counters plus a 40-sample frame capture
  int          a_pops = 0, a_dones = 0, a_busyc = 0, a_badpop = 0;
  logic [39:0] a_frames[$];
  int          a_gaps[$];
  int          dcnt = 0, hrun = 0;
  logic [39:0] dsh = '0;
  bit          dact = 1'b0, dseen = 1'b0;

  always @(negedge clk) begin
    if (a_pop) a_pops++;
    if (a_pop && a_empty) a_badpop++;
    if (a_done) a_dones++;
    if (a_busy) a_busyc++;
    if (a_rst) begin
      dact = 1'b0; dseen = 1'b0; hrun = 0;
    end else if (dact) begin
      dsh = {a_tx, dsh[39:1]};
      dcnt++;
      if (dcnt == 40) begin
        a_frames.push_back(dsh);
        dact = 1'b0;
        hrun = 0;
      end
    end else if (a_tx == 1'b0) begin
      if (dseen) a_gaps.push_back(hrun);
      dseen = 1'b1;
      dact  = 1'b1;
      dsh   = {1'b0, 39'h0};
      dcnt  = 1;
    end else begin
      hrun++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input bit to_a, input logic [7:0] v);
    @(negedge clk);
    if (to_a) begin a_wd = v; a_wr = 1'b1; end
    else      begin b_wd = v; b_wr = 1'b1; end
    @(negedge clk);
    a_wr = 1'b0;
    b_wr = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    while (a_frames.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(tag, a_frames.size(), n);
  endtask

  task automatic wait_start_a(input string tag);
    int bud = 40;
    while (a_tx !== 1'b0 && bud > 0) begin
      @(negedge clk);
      bud--;
    end
    chk(tag, a_tx, 0);
  endtask

  // Sample i of a 4-clk/bit frame carries frame bit i/4 (start, d0..d7, stop)
  function automatic logic [39:0] frame4(input logic [7:0] d);
    logic [9:0]  lv;
    logic [39:0] f;
    lv = {1'b1, d, 1'b0};
    for (int i = 0; i < 40; i++) f[i] = lv[i / 4];
    return f;
  endfunction

  localparam bit [0:9] A5_SEQ = 10'b0101001011;

  initial begin
    int p0, f0, g0, d0, bz0, lowc, pr, t, ts, bud;
    logic [39:0] a5_exp;
    logic [7:0]  three [3];
    logic        lvl;

    a_rst = 1'b1; b_rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",   a_tx,   1);
    chk("rst_pop",  a_pop,  0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_b_tx", b_tx,   1);
    a_rst = 1'b0; b_rst = 1'b0;

    // empty FIFO with en=1: never pops, line idles
    a_en = 1'b1;
    p0 = a_pops; bz0 = a_busyc; lowc = 0;
    repeat (200) begin
      @(negedge clk);
      if (a_tx !== 1'b1) lowc++;
    end
    chk("empty_pops", a_pops - p0, 0);
    chk("empty_txlow", lowc, 0);
    chk("empty_busy", a_busyc - bz0, 0);

    // single byte 0xA5
    for (int i = 0; i < 40; i++) a5_exp[i] = A5_SEQ[i / 4];
    p0 = a_pops; d0 = a_dones; bz0 = a_busyc; f0 = a_frames.size();
    push(1'b1, 8'hA5);
    wait_frames(f0 + 1, 100, "a5_frame_seen");
    repeat (5) @(negedge clk);
    chk("a5_pops", a_pops - p0, 1);
    chk("a5_frame", a_frames[f0], a5_exp);
    chk("a5_done", a_dones - d0, 1);
    chk("a5_busy_cycles", a_busyc - bz0, 42);

    // three back-to-back bytes
    three[0] = 8'h00; three[1] = 8'hFF; three[2] = 8'h3C;
    p0 = a_pops; f0 = a_frames.size(); g0 = a_gaps.size();
    for (int i = 0; i < 3; i++) push(1'b1, three[i]);
    wait_frames(f0 + 3, 300, "b2b_frames_seen");
    repeat (5) @(negedge clk);
    chk("b2b_pops", a_pops - p0, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_frame%0d", i), a_frames[f0 + i], frame4(three[i]));
    chk("b2b_gap_count", a_gaps.size() - g0, 3);
    chk("b2b_gap1", a_gaps[g0 + 1], 3);
    chk("b2b_gap2", a_gaps[g0 + 2], 3);

    // en dropped during data bit 3 of 0x81 with 0x42 queued behind it
    p0 = a_pops; f0 = a_frames.size();
    push(1'b1, 8'h81);
    push(1'b1, 8'h42);
    wait_start_a("endrop_start");
    repeat (17) @(negedge clk);
    a_en = 1'b0;
    wait_frames(f0 + 1, 100, "endrop_frame_seen");
    repeat (100) @(negedge clk);
    chk("endrop_pops_held", a_pops - p0, 1);
    chk("endrop_frame81", a_frames[f0], frame4(8'h81));
    chk("endrop_busy", a_busy, 0);
    chk("endrop_tx_idle", a_tx, 1);
    a_en = 1'b1;
    wait_frames(f0 + 2, 100, "endrop_second_seen");
    chk("endrop_frame42", a_frames[f0 + 1], frame4(8'h42));
    chk("endrop_pops_after", a_pops - p0, 2);

    // reset during data bit 5 of 0x5A; 0x99 queued behind it
    repeat (5) @(negedge clk);
    p0 = a_pops;
    push(1'b1, 8'h5A);
    push(1'b1, 8'h99);
    wait_start_a("rst_mid_start");
    repeat (25) @(negedge clk);
    pr = a_pops;
    a_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", a_tx, 1);
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_pop", a_pop, 0);
    repeat (9) @(negedge clk);
    chk("rst_mid_nopop", a_pops - pr, 0);
    f0 = a_frames.size();
    a_rst = 1'b0;
    wait_frames(f0 + 1, 100, "rst_mid_next_seen");
    chk("rst_mid_frame99", a_frames[f0], frame4(8'h99));
    chk("rst_mid_pops", a_pops - p0, 2);
    chk("rst_mid_fifo_drained", a_q.size(), 0);

    // 868 clks/bit with 0x55: every bit boundary is a transition
    b_en = 1'b1;
    push(1'b0, 8'h55);
    bud = 40;
    while (b_tx !== 1'b0 && bud > 0) begin
      @(negedge clk);
      bud--;
    end
    chk("b868_start", b_tx, 0);
    t = cyc; ts = cyc;
    for (int k = 0; k < 9; k++) begin
      lvl = b_tx;
      bud = 2000;
      while (b_tx === lvl && bud > 0) begin
        @(negedge clk);
        bud--;
      end
      chk($sformatf("b868_bit%0d", k), cyc - t, 868);
      t = cyc;
    end
    bud = 2000;
    while (b_done !== 1'b1 && bud > 0) begin
      @(negedge clk);
      bud--;
    end
    chk("b868_stop", cyc - t, 868);
    chk("b868_frame_len", cyc - ts, 8680);

    chk("no_pop_when_empty", a_badpop, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
